// File: rtl/smaesh_inv_pkg.sv
// Shared constants, FSM state type and byte-slice helper for the masked inverse-round datapath.
// Combinational definitions only; no latency and no flow control.
package smaesh_inv_pkg;
  localparam int BYTE_BITS   = 8;
  localparam int ROWS        = 4;
  localparam int COLS        = 4;
  localparam int STATE_BYTES = 16;

  typedef enum logic {IDLE, EMIT} ser_state_e;

  // LSB of byte k in a d-share bus; the byte occupies [byte_lsb(k,d) +: BYTE_BITS*d].
  function automatic int byte_lsb(input int k, input int d);
    return BYTE_BITS * d * k;
  endfunction
endpackage

// File: rtl/msk_ark_sharewise.sv
// Sharewise masked AddRoundKey: bitwise XOR of two d-share sharings, shares never mixed.
// Purely combinational, zero latency, no flow control.
module msk_ark_sharewise
  import smaesh_inv_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [STATE_BYTES*BYTE_BITS*d-1:0] a,
  input  logic [STATE_BYTES*BYTE_BITS*d-1:0] b,
  output logic [STATE_BYTES*BYTE_BITS*d-1:0] y
);
  // Identical share index on both operands, so the map is affine per share.
  assign y = a ^ b;
endmodule

// File: rtl/msk_inv_round_col_serializer.sv
// Loads masked state^key in one transfer and emits one masked column per beat; first column 1 cycle after load.
// Outputs held while out_ready is low; a new state is accepted only in IDLE or on the column-3 accept.
module msk_inv_round_col_serializer
  import smaesh_inv_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [STATE_BYTES*BYTE_BITS*d-1:0] in_state,
  input  logic [STATE_BYTES*BYTE_BITS*d-1:0] in_key,
  input  logic                              in_skip_mc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BYTE_BITS*d-1:0]            out_b0,
  output logic [BYTE_BITS*d-1:0]            out_b1,
  output logic [BYTE_BITS*d-1:0]            out_b2,
  output logic [BYTE_BITS*d-1:0]            out_b3,
  output logic [1:0]                        out_col,
  output logic                              out_last,
  output logic                              out_skip_mc
);
  localparam int SW = STATE_BYTES * BYTE_BITS * d;
  localparam int BW = BYTE_BITS * d;
  localparam int CW = ROWS * BW;

  ser_state_e      fsm_q;
  logic [1:0]      cnt_q;
  logic [SW-1:0]   state_q;
  logic            skip_q;
  logic [SW-1:0]   ark;
  logic [CW-1:0]   col_w;
  logic            load;

  msk_ark_sharewise #(.d(d)) u_ark (
    .a (in_state),
    .b (in_key),
    .y (ark)
  );

  assign in_ready = (fsm_q == IDLE) || ((cnt_q == 2'd3) && out_ready);
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      cnt_q   <= 2'd0;
      state_q <= '0;
      skip_q  <= 1'b0;
    end else if (load) begin
      fsm_q   <= EMIT;
      cnt_q   <= 2'd0;
      state_q <= ark;
      skip_q  <= in_skip_mc;
    end else if (fsm_q == EMIT && out_ready) begin
      if (cnt_q == 2'd3) begin
        // Column index parks at 0 in IDLE so out_col/out_last read as idle values.
        fsm_q <= IDLE;
        cnt_q <= 2'd0;
      end else begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Column c holds bytes 4c..4c+3, contiguous in the state register.
  assign col_w = state_q[int'(cnt_q) * CW +: CW];

  assign out_valid   = (fsm_q == EMIT);
  assign out_b0      = col_w[byte_lsb(0, d) +: BW];
  assign out_b1      = col_w[byte_lsb(1, d) +: BW];
  assign out_b2      = col_w[byte_lsb(2, d) +: BW];
  assign out_b3      = col_w[byte_lsb(3, d) +: BW];
  assign out_col     = cnt_q;
  assign out_last    = (cnt_q == 2'd3);
  assign out_skip_mc = skip_q;
endmodule

// File: tb/tb_msk_inv_round_col_serializer.sv
// Directed, table-driven check of the masked column serializer at d=2.
module tb_msk_inv_round_col_serializer;
  localparam int D  = 2;
  localparam int SW = 128 * D;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_state;
  logic [SW-1:0] in_key;
  logic          in_skip_mc;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_b0, out_b1, out_b2, out_b3;
  logic [1:0]    out_col;
  logic          out_last;
  logic          out_skip_mc;

  int n_tests = 0;
  int n_fail  = 0;

  msk_inv_round_col_serializer #(.d(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .in_key      (in_key),
    .in_skip_mc  (in_skip_mc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_b0      (out_b0),
    .out_b1      (out_b1),
    .out_b2      (out_b2),
    .out_b3      (out_b3),
    .out_col     (out_col),
    .out_last    (out_last),
    .out_skip_mc (out_skip_mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  col;
    logic [31:0] s0;   // share0 bytes of rows 0..3, row 0 in the top byte
    logic [7:0]  s1;   // share1 value, identical in every byte
    logic        last;
    logic        skip;
  } vec_t;

  vec_t vecs [8];

  // Interleave two share bytes: bit j of share i at index 2*j+i.
  function automatic logic [15:0] enc(input logic [7:0] s0, input logic [7:0] s1);
    logic [15:0] r;
    for (int j = 0; j < 8; j++) begin
      r[2*j]   = s0[j];
      r[2*j+1] = s1[j];
    end
    return r;
  endfunction

  function automatic logic [7:0] dec(input logic [15:0] b, input int sh);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = b[2*j+sh];
    return r;
  endfunction

  // 0: state1 (s0=k, s1=0)  1: key1 (FF, A5)  2: state2 (s0=0x11*k, s1=5A)  3: key2 (0F, 3C)
  function automatic logic [SW-1:0] build(input int mode);
    logic [SW-1:0] v;
    logic [7:0] a, b, kk;
    for (int k = 0; k < 16; k++) begin
      kk = 8'(k);
      case (mode)
        0:       begin a = kk;                  b = 8'h00; end
        1:       begin a = 8'hFF;               b = 8'hA5; end
        2:       begin a = {kk[3:0], kk[3:0]};  b = 8'h5A; end
        default: begin a = 8'h0F;               b = 8'h3C; end
      endcase
      v[16*k +: 16] = enc(a, b);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat_chk(input string tag, input logic [1:0] col, input logic [31:0] s0,
                          input logic [7:0] s1, input logic last, input logic skip,
                          input logic rdy);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".col"}, {30'd0, out_col}, {30'd0, col});
    chk({tag, ".s0"}, {dec(out_b0, 0), dec(out_b1, 0), dec(out_b2, 0), dec(out_b3, 0)}, s0);
    chk({tag, ".s1"}, {dec(out_b0, 1), dec(out_b1, 1), dec(out_b2, 1), dec(out_b3, 1)},
        {s1, s1, s1, s1});
    chk({tag, ".last"}, {31'd0, out_last}, {31'd0, last});
    chk({tag, ".skip"}, {31'd0, out_skip_mc}, {31'd0, skip});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // state1 ^ key1: share0 = ~k, share1 = A5; state2 ^ key2: share0 = 0x11k^0F, share1 = 66
    vecs[0] = '{2'd0, 32'hFFFEFDFC, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{2'd1, 32'hFBFAF9F8, 8'hA5, 1'b0, 1'b1};
    vecs[2] = '{2'd2, 32'hF7F6F5F4, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{2'd3, 32'hF3F2F1F0, 8'hA5, 1'b1, 1'b1};
    vecs[4] = '{2'd0, 32'h0F1E2D3C, 8'h66, 1'b0, 1'b0};
    vecs[5] = '{2'd1, 32'h4B5A6978, 8'h66, 1'b0, 1'b0};
    vecs[6] = '{2'd2, 32'h8796A5B4, 8'h66, 1'b0, 1'b0};
    vecs[7] = '{2'd3, 32'hC3D2E1F0, 8'h66, 1'b1, 1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_state   = '0;
    in_key     = '0;
    in_skip_mc = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    idle_chk("rst");
    chk("rst.b", {out_b0, out_b1}, 32'd0);
    chk("rst.b23", {out_b2, out_b3}, 32'd0);
    chk("rst.col_last_skip", {29'd0, out_col, out_last, out_skip_mc}, 32'd0);

    // Table pass: state1 (skip=1) then state2 (skip=0) presented early and held back-to-back.
    in_valid   = 1'b1;
    in_state   = build(0);
    in_key     = build(1);
    in_skip_mc = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_state   = build(2);
    in_key     = build(3);
    in_skip_mc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat_chk($sformatf("vec%0d", i), vecs[i].col, vecs[i].s0, vecs[i].s1,
               vecs[i].last, vecs[i].skip, vecs[i].last);
      if (i == 4) in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    idle_chk("after_b2b");
    chk("after_b2b.col", {30'd0, out_col}, 32'd0);

    // Backpressure: stall 5 cycles on column 1.
    in_valid   = 1'b1;
    in_state   = build(0);
    in_key     = build(1);
    in_skip_mc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    beat_chk("bp.c0", 2'd0, vecs[0].s0, 8'hA5, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      beat_chk($sformatf("bp.hold%0d", i), 2'd1, vecs[1].s0, 8'hA5, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    beat_chk("bp.c2", 2'd2, vecs[2].s0, 8'hA5, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while column 2 is on the outputs.
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.b0", {16'd0, out_b0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      idle_chk($sformatf("post_rst%0d", i));
      @(posedge clk);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/msk_inv_round_col_serializer.md
Name: msk_inv_round_col_serializer

Overview:
- Sharewise masked AddRoundKey plus column serializer for the decryption datapath.
- Accepts a full masked 128-bit state and a masked round key in one transfer, XORs them sharewise, and emits one masked column per accepted beat.
- Sits directly upstream of the masked inverse-MixColumns stage; outputs b0..b3 connect 1:1 to its a0..a3 inputs.
- Carries a per-state skip flag so the consumer can bypass inverse-MixColumns in the final round.

Parameters:
- d, 2, number of shares (masking order d-1); must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  state/key transfer valid.
- in_ready  output  1  block can accept a state/key transfer.
- in_state  input  128*d  masked state; byte k (0..15) at [8*d*k +: 8*d]; within a byte, bit j of share i at index d*j+i.
- in_key  input  128*d  masked round key, same encoding as in_state.
- in_skip_mc  input  1  final-round flag; sampled with the state.
- out_valid  output  1  column beat valid.
- out_ready  input  1  consumer accepts column beat.
- out_b0..out_b3  output  8*d each  rows 0..3 of the current column: bytes 4c+0..4c+3, same bit/share encoding.
- out_col  output  2  current column index c.
- out_last  output  1  high when out_col==3.
- out_skip_mc  output  1  registered in_skip_mc of the current state.

Behaviour:
- FSM states: IDLE and EMIT; a 2-bit column counter cnt is used in EMIT.
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE, cnt=0.
  - State register and skip register cleared to 0.
  - out_valid=0, out_b*=0, out_col=0, out_last=0, out_skip_mc=0.
  - in_ready=1 as soon as reset deasserts.
- in_ready = (FSM==IDLE) || (FSM==EMIT && cnt==3 && out_ready). This is a combinational path from out_ready.
- Load: on in_valid && in_ready:
  - State register takes in_state ^ in_key, bitwise. This is sharewise XOR; shares are never combined.
  - skip register takes in_skip_mc.
  - cnt is set to 0 and FSM goes to EMIT.
- EMIT:
  - out_valid=1.
  - out_b* are driven from registered bytes of column cnt only, with no logic between the register and the port beyond the column mux.
  - On out_valid && out_ready: if cnt<3, cnt increments. If cnt==3, FSM returns to IDLE, unless a load happens in the same cycle; in that case FSM stays in EMIT with cnt=0 and the new state loaded.
- Back-to-back throughput is 4 beats per state with no bubble. Latency from load to first column valid is 1 cycle.
- Backpressure: while out_valid && !out_ready, out_b*, out_col, out_last and out_skip_mc are held stable.
- in_valid in EMIT with cnt<3 is not accepted (in_ready=0); the producer must hold its data.
- cnt wraps only through the cnt==3 transition; the value 3 never increments to 0 without an accept.
- Reset mid-EMIT discards the partially emitted state; no further beats for it.
- Any bit flip in one share of the input changes only the same share of the output (sharewise property, formally checked as affine).

Decomposition:
- Package smaesh_inv_pkg holds:
  - constants: BYTE_BITS=8, ROWS=4, COLS=4, STATE_BYTES=16;
  - the FSM state enum {IDLE, EMIT};
  - a function giving the bit slice of byte k for d shares.
- Sub-module msk_ark_sharewise: combinational sharewise XOR of two 128*d sharings. It is kept separate so it can carry its own affine verification annotation.

Test Plan:
- Reset then idle: assert rst_n=0 for 3 cycles, release -> in_ready=1, out_valid=0, all outputs 0.
- Single state, d=2, no backpressure:
  - Stimulus: share0 of in_state = bytes 0x00..0x0F, share1 = 0; in_key share0 = 0xFF in every byte, share1 = 0xA5 in every byte; out_ready held 1.
  - Required: 4 beats, out_col=0,1,2,3, out_last only on the 4th beat.
  - Column 0 decoded share0 = {0xFF,0xFE,0xFD,0xFC}, share1 = 0xA5 in every byte.
  - in_ready=0 during beats 0..2.
- Backpressure: out_ready=0 for 5 cycles at column 1 -> out_col stays 1 and data is stable; resumes at column 2 after out_ready=1.
- Back-to-back: second state presented with in_valid=1 during column-3 accept -> accepted that cycle, its column 0 appears the next cycle, no idle cycle.
- Skip flag: load with in_skip_mc=1, then the next state with 0 -> out_skip_mc=1 on the 4 beats of state 1 and 0 on the 4 beats of state 2.
- Reset mid-operation: drop rst_n during column 2 -> out_valid=0 immediately (asynchronous); after release in_ready=1 and no stale beats appear.
